decode_stage: RTL

- Next-generation decode pipeline stage: a parametrised-depth instruction queue in front of the existing combinational `decoder`, followed by a registered decoded-output stage.
- Adds valid/ready handshakes on both sides, flush, load-use interlock, sticky halt and an x0 write-enable mask.
- Sits between fetch and register-read/execute in the core.

---
 rtl/decode_stage.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction queue -> combinational decoder -> registered decoded output.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        fetch-side handshake, in_inst/in_pc payload
//   flush                    drop every queued and registered instruction
//   out_valid/out_ready      downstream handshake for the decoded output register
//   out_pc, src1_reg, src2_reg, dst_reg, imm, alu_code, alu_op1_type, alu_op2_type,
//   reg_w_enable, is_load, is_store, is_halt   decoded fields of the output instruction
//   halted                   sticky, set once a halt instruction is accepted downstream
//   count                    queue occupancy
module decode_stage #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [4:0]       src1_reg,
    output logic [4:0]       src2_reg,
    output logic [4:0]       dst_reg,
    output logic [31:0]      imm,
    output logic [5:0]       alu_code,
    output logic [1:0]       alu_op1_type,
    output logic [1:0]       alu_op2_type,
    output logic             reg_w_enable,
    output logic             is_load,
    output logic             is_store,
    output logic             is_halt,
    output logic             halted,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    // alu_code[5:4] class: 0 arith/logic, 1 branch compare, 2 address/link add, 3 pass-through
    // alu_op1_type: 0 rs1, 1 pc, 2 zero.  alu_op2_type: 0 rs2, 1 imm, 2 constant 4
    typedef struct packed {
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [5:0]  alu_code;
        logic [1:0]  op1_type;
        logic [1:0]  op2_type;
        logic        reg_w_enable;
        logic        is_load;
        logic        is_store;
        logic        is_halt;
    } dec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    // RV32I field decoder; unused register fields are reported as x0 so they never interlock
    function automatic dec_t decoder(input logic [31:0] inst);
        dec_t        d;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        opcode = inst[6:0];
        funct3 = inst[14:12];
        rd     = inst[11:7];
        rs1    = inst[19:15];
        rs2    = inst[24:20];
        imm_i  = {{20{inst[31]}}, inst[31:20]};
        imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        imm_u  = {inst[31:12], 12'h000};
        imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        d = '0;
        case (opcode)
            OPC_OP: begin
                d.src1 = rs1; d.src2 = rs2; d.dst = rd;
                d.alu_code = {2'd0, inst[30], funct3};
            end
            OPC_OP_IMM: begin
                d.src1 = rs1; d.dst = rd; d.imm = imm_i; d.op2_type = 2'd1;
                d.alu_code = {2'd0, (funct3 == 3'd5) && inst[30], funct3};
            end
            OPC_LOAD: begin
                d.src1 = rs1; d.dst = rd; d.imm = imm_i; d.op2_type = 2'd1;
                d.alu_code = 6'h20; d.is_load = 1'b1;
            end
            OPC_STORE: begin
                d.src1 = rs1; d.src2 = rs2; d.imm = imm_s; d.op2_type = 2'd1;
                d.alu_code = 6'h20; d.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                d.src1 = rs1; d.src2 = rs2; d.imm = imm_b;
                d.alu_code = {2'd1, 1'b0, funct3};
            end
            OPC_LUI: begin
                d.dst = rd; d.imm = imm_u; d.op1_type = 2'd2; d.op2_type = 2'd1;
                d.alu_code = 6'h30;
            end
            OPC_AUIPC: begin
                d.dst = rd; d.imm = imm_u; d.op1_type = 2'd1; d.op2_type = 2'd1;
                d.alu_code = 6'h20;
            end
            OPC_JAL: begin
                d.dst = rd; d.imm = imm_j; d.op1_type = 2'd1; d.op2_type = 2'd2;
                d.alu_code = 6'h20;
            end
            OPC_JALR: begin
                d.src1 = rs1; d.dst = rd; d.imm = imm_i; d.op2_type = 2'd2;
                d.alu_code = 6'h20;
            end
            OPC_SYSTEM: begin
                d.alu_code = 6'h30;
                d.is_halt  = (funct3 == 3'd0);
            end
            default: ;
        endcase
        d.reg_w_enable = (d.dst != 5'd0);
        return d;
    endfunction

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_pc_q, out_pc_d;
    dec_t               out_q, out_d;
    logic               halted_q, halted_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               accept;
    logic               out_free;
    logic               interlock;
    logic               issue;
    dec_t               head_dec;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && !halted_q;
    assign push     = in_valid && in_ready;
    assign accept   = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;
    assign head_dec = decoder(mem_q[rd_ptr_q].inst);

    // load in the output register blocks any head reading its destination, even after acceptance
    assign interlock = out_valid_q && out_q.is_load && (out_q.dst != 5'd0) &&
                       ((head_dec.src1 == out_q.dst) || (head_dec.src2 == out_q.dst));

    // a halt sitting in the output register already stops issue, so nothing follows it
    assign issue = out_free && !empty && !interlock && !halted_q &&
                   !(out_valid_q && out_q.is_halt);

    // next-state for queue, output register and halt flag
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_d       = out_q;
        halted_d    = halted_q || (accept && out_q.is_halt);

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry_t'{inst: in_inst, pc: in_pc};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                out_d    = head_dec;
                out_pc_d = mem_q[rd_ptr_q].pc;
            end
            if (out_free) begin
                out_valid_d = issue;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(issue);
        end
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_q       <= '0;
            halted_q    <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_q       <= out_d;
            halted_q    <= halted_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign src1_reg     = out_q.src1;
    assign src2_reg     = out_q.src2;
    assign dst_reg      = out_q.dst;
    assign imm          = out_q.imm;
    assign alu_code     = out_q.alu_code;
    assign alu_op1_type = out_q.op1_type;
    assign alu_op2_type = out_q.op2_type;
    assign reg_w_enable = out_q.reg_w_enable;
    assign is_load      = out_q.is_load;
    assign is_store     = out_q.is_store;
    assign is_halt      = out_q.is_halt;
    assign halted       = halted_q;
    assign count        = count_q;

endmodule
